// File: rtl/wb_master_bridge.sv
// rtl/wb_master_bridge.sv - Wishbone classic initiator for the datapath data-memory port
// Turns single-cycle load/store requests into registered single transfers with ACK timeout.
module wb_master_bridge #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            TIMEOUT  = 15,
  parameter logic [DW-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_read,
  input  logic            cpu_write,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  input  logic [DW/8-1:0] cpu_sel,
  output logic [DW-1:0]   cpu_rdata,
  output logic            cpu_stall,
  output logic            bus_err,
  output logic [AW-1:0]   ADR_O,
  output logic [DW-1:0]   DAT_O,
  input  logic [DW-1:0]   DAT_I,
  output logic            WE_O,
  output logic [DW/8-1:0] SEL_O,
  output logic            STB_O,
  output logic            CYC_O,
  input  logic            ACK_I
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          req;

  assign req = cpu_read | cpu_write;

  // DONE releases the stall so the datapath advances on the edge ending DONE.
  always_comb begin
    cpu_stall = 1'b0;
    if (!reset) begin
      case (state)
        S_IDLE:  cpu_stall = req;
        S_BUS:   cpu_stall = 1'b1;
        default: cpu_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ADR_O     <= '0;
      DAT_O     <= '0;
      SEL_O     <= '0;
      WE_O      <= 1'b0;
      STB_O     <= 1'b0;
      CYC_O     <= 1'b0;
      cpu_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bus_err <= 1'b0;
          if (req) begin
            ADR_O <= cpu_addr;
            DAT_O <= cpu_wdata;
            SEL_O <= cpu_sel;
            WE_O  <= cpu_write;
            CYC_O <= 1'b1;
            STB_O <= 1'b1;
            cnt   <= '0;
            state <= S_BUS;
          end
        end
        S_BUS: begin
          // ACK has priority over a timeout expiring on the same edge.
          if (ACK_I) begin
            if (!WE_O) cpu_rdata <= DAT_I;
            CYC_O <= 1'b0;
            STB_O <= 1'b0;
            WE_O  <= 1'b0;
            state <= S_DONE;
          end else begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              if (!WE_O) cpu_rdata <= ERR_DATA;
              CYC_O   <= 1'b0;
              STB_O   <= 1'b0;
              WE_O    <= 1'b0;
              bus_err <= 1'b1;
              state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          bus_err <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          bus_err <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// tb/tb_wb_master_bridge.sv - randomized self-checking bench for wb_master_bridge
// Transaction-level model: RAM array, expected BUS length min(k,TIMEOUT), error iff no ACK in time.
module tb_wb_master_bridge;
  localparam int TIMEOUT = 15;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_sel = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, bus_err;
  logic [31:0] ADR_O, DAT_O;
  logic [31:0] DAT_I = '0;
  logic        WE_O, STB_O, CYC_O;
  logic [3:0]  SEL_O;
  logic        ACK_I = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc_rises = 0;

  logic [31:0] ram [0:63];
  logic [31:0] last_rdata;

  wb_master_bridge #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_sel(cpu_sel), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .bus_err(bus_err),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .WE_O(WE_O),
    .SEL_O(SEL_O), .STB_O(STB_O), .CYC_O(CYC_O), .ACK_I(ACK_I)
  );

  always #5 clk = ~clk;
  always @(posedge CYC_O) cyc_rises++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    lane_mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  // k = BUS cycle on which the slave ACKs; k > TIMEOUT means the slave never answers.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] sel, input int k);
    bit          err;
    int          len;
    logic [31:0] m;
    err = (k > TIMEOUT);
    len = err ? TIMEOUT : k;
    @(negedge clk);
    cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata; cpu_sel = sel;
    #1;
    check("idle_stall", {31'b0, cpu_stall}, 32'd1);
    check("idle_cyc", {31'b0, CYC_O}, 32'd0);
    for (int n = 1; n <= len; n++) begin
      @(negedge clk);
      check("bus_cyc", {30'b0, CYC_O, STB_O}, 32'd3);
      check("bus_adr", ADR_O, addr);
      check("bus_dat", DAT_O, wdata);
      check("bus_we", {31'b0, WE_O}, {31'b0, wr});
      check("bus_sel", {28'b0, SEL_O}, {28'b0, sel});
      check("bus_stall", {31'b0, cpu_stall}, 32'd1);
      cpu_addr = $urandom; cpu_wdata = $urandom; cpu_sel = 4'($urandom);
      ACK_I = (n == k);
      DAT_I = (n == k && !wr) ? ram[addr[7:2]] : $urandom;
    end
    if (wr && !err) begin
      m = lane_mask(sel);
      ram[addr[7:2]] = (ram[addr[7:2]] & ~m) | (wdata & m);
    end
    if (!wr) last_rdata = err ? ERR_DATA : ram[addr[7:2]];
    @(negedge clk);
    ACK_I = 1'b0; DAT_I = $urandom;
    #1;
    check("done_cyc", {30'b0, CYC_O, STB_O}, 32'd0);
    check("done_stall", {31'b0, cpu_stall}, 32'd0);
    check("done_err", {31'b0, bus_err}, {31'b0, err});
    check("done_rdata", cpu_rdata, last_rdata);
  endtask

  task automatic go_idle(input int cycles);
    cpu_read = 1'b0; cpu_write = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      #1;
      check("idle_nocyc", {30'b0, CYC_O, STB_O}, 32'd0);
      check("idle_nostall", {31'b0, cpu_stall}, 32'd0);
      check("idle_noerr", {31'b0, bus_err}, 32'd0);
    end
  endtask

  initial begin
    int c0, r;
    for (int i = 0; i < 64; i++) ram[i] = '0;
    last_rdata = '0;

    // reset applied mid-cycle clears outputs without a clock edge
    #3 reset = 1'b1;
    #1;
    check("rst_bus", {ADR_O[0], DAT_O[0], SEL_O, WE_O, STB_O, CYC_O} === 9'b0 ? 32'd0 : 32'd1, 32'd0);
    check("rst_adr", ADR_O, 32'd0);
    check("rst_dat", DAT_O, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_err", {31'b0, bus_err}, 32'd0);
    cpu_read = 1'b1;
    #1 check("rst_stall", {31'b0, cpu_stall}, 32'd0);
    cpu_read = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    go_idle(10);

    // zero-wait read
    ram[4] = 32'h12345678;
    do_txn(1, 0, 32'h10, 32'h0, 4'hF, 1);
    go_idle(1);
    // write with three wait cycles, then read it back
    do_txn(0, 1, 32'h20, 32'hA5A5A5A5, 4'b1111, 3);
    go_idle(1);
    do_txn(1, 0, 32'h20, 32'h0, 4'hF, 2);
    go_idle(1);
    // timeout, then ACK exactly on the last allowed cycle
    do_txn(1, 0, 32'h30, 32'h0, 4'hF, TIMEOUT + 1);
    go_idle(1);
    ram[12] = 32'h0BADF00D;
    do_txn(1, 0, 32'h30, 32'h0, 4'hF, TIMEOUT);
    go_idle(1);
    do_txn(0, 1, 32'h34, 32'h11112222, 4'b0101, TIMEOUT + 1);
    go_idle(1);

    // reset in the second BUS cycle, later ACK must be ignored
    @(negedge clk);
    cpu_read = 1'b1; cpu_addr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_cyc", {30'b0, CYC_O, STB_O}, 32'd0);
    check("mid_rst_stall", {31'b0, cpu_stall}, 32'd0);
    check("mid_rst_rdata", cpu_rdata, 32'd0);
    last_rdata = '0;
    cpu_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ACK_I = 1'b1; DAT_I = 32'hFFFFFFFF;
    go_idle(1);
    ACK_I = 1'b0;
    go_idle(2);
    check("mid_rst_rdata2", cpu_rdata, 32'd0);

    // back-to-back read then write held through DONE, and read+write conflict
    c0 = cyc_rises;
    do_txn(1, 0, 32'h10, 32'h0, 4'hF, 1);
    do_txn(0, 1, 32'h14, 32'hCAFEF00D, 4'b0011, 2);
    go_idle(1);
    check("b2b_cycles", 32'(cyc_rises - c0), 32'd2);
    do_txn(1, 1, 32'h18, 32'h76543210, 4'b1100, 1);
    go_idle(1);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      int k;
      r = $urandom_range(0, 2);
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TIMEOUT + 2) : $urandom_range(1, 3);
      do_txn(r != 1, r != 0, {24'b0, 6'($urandom), 2'b00}, $urandom, 4'($urandom), k);
      if ($urandom_range(0, 1) == 1) go_idle($urandom_range(1, 2));
    end
    go_idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
Wishbone initiator that sits between the pipeline datapath's data-memory port (MemRead/MemWrite, MemAddr, WriteData) and the Wishbone-slave data RAM.
- Converts single-cycle CPU load/store requests into registered Wishbone classic single transfers.
- Stalls the CPU until the slave acknowledges or a timeout expires.
- Returns read data and a bus-error flag to the datapath.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 15, max cycles waiting for ACK_I before aborting (must be >=1)
ERR_DATA, 32'hDEADBEEF, value returned on cpu_rdata after a timeout

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cpu_read  input  1  load request (MemRead)
cpu_write  input  1  store request (MemWrite)
cpu_addr  input  AW  byte address (MemAddr)
cpu_wdata  input  DW  store data (WriteData)
cpu_sel  input  DW/8  byte-lane enables
cpu_rdata  output  DW  load data, valid in DONE and held until next completion
cpu_stall  output  1  1 = datapath must freeze
bus_err  output  1  1-cycle pulse in DONE when transfer timed out
ADR_O  output  AW  Wishbone address
DAT_O  output  DW  Wishbone write data
DAT_I  input  DW  Wishbone read data
WE_O  output  1  Wishbone write enable
SEL_O  output  DW/8  Wishbone byte select
STB_O  output  1  Wishbone strobe
CYC_O  output  1  Wishbone cycle
ACK_I  input  1  Wishbone acknowledge

Behaviour:
- Reset (asynchronous, active-high, applies immediately, including mid-transfer):
  - state=IDLE; CYC_O=STB_O=WE_O=0; ADR_O=DAT_O=0; SEL_O=0; cpu_rdata=0; bus_err=0; timeout counter=0.
  - cpu_stall=0 while reset is high.
- All Wishbone outputs are registered; CYC_O and STB_O are always equal.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - Request = cpu_read|cpu_write.
  - cpu_stall = request (combinational), so the CPU holds its request.
  - On a clock edge with a request:
    - latch ADR_O<=cpu_addr, DAT_O<=cpu_wdata, SEL_O<=cpu_sel, WE_O<=cpu_write;
    - set CYC_O=STB_O=1; clear the counter; go to BUS.
  - If cpu_read and cpu_write are both high, the write wins (WE_O=1).
- BUS:
  - cpu_stall=1. All latched outputs are stable; CPU-side inputs are ignored.
  - Counter increments each cycle ACK_I=0.
  - ACK_I=1 on an edge:
    - if WE_O=0, cpu_rdata<=DAT_I;
    - CYC_O=STB_O=WE_O<=0; go to DONE.
  - Counter reaching TIMEOUT with no ACK:
    - cpu_rdata<=ERR_DATA (reads only; writes leave cpu_rdata unchanged);
    - drop CYC/STB/WE; assert bus_err; go to DONE.
  - If ACK_I arrives on the same edge the timeout expires, ACK wins (no error).
- DONE:
  - Lasts exactly one cycle; cpu_stall=0 so the datapath advances on this edge.
  - bus_err is high only in this cycle and only after a timeout.
  - CPU request inputs are ignored (they belong to the completed access). Next state is IDLE.
- Latency:
  - Request seen in IDLE at cycle 0; CYC/STB high from cycle 1.
  - With ACK_I in cycle k (k>=1), DONE occurs in cycle k+1.
  - Minimum stall is 2 cycles (cycles 0 and 1); the CPU resumes at the end of cycle 2.
- ACK_I outside BUS is ignored.
- Counter width is ceil(log2(TIMEOUT+1)); it saturates and never wraps.
- ADR_O is passed through unaligned; alignment is the slave's responsibility.

Test Plan:
1. Reset then idle: reset=1 mid-cycle -> all outputs 0 immediately. Release with no request -> CYC_O stays 0 and cpu_stall=0 for 10 cycles.
2. Single read, zero-wait slave (ACK the cycle after STB): cpu_read=1, addr=0x10, RAM[0x10]=0x12345678 -> CYC_O/STB_O high exactly 1 cycle, WE_O=0, ADR_O=0x10, cpu_stall high 2 cycles, cpu_rdata=0x12345678 in DONE.
3. Write with 3-cycle wait: cpu_write=1, addr=0x20, wdata=0xA5A5A5A5, sel=4'b1111, ACK_I on the 3rd BUS cycle -> WE_O=1 and DAT_O=0xA5A5A5A5 stable for all 3 cycles. A later read of 0x20 returns 0xA5A5A5A5.
4. Timeout: cpu_read=1 and ACK_I held 0 -> after 15 BUS cycles CYC_O drops, bus_err pulses 1 cycle, cpu_rdata=0xDEADBEEF. A repeat with ACK_I exactly on cycle 15 gives bus_err=0.
5. Reset mid-transfer: assert reset in the 2nd BUS cycle -> CYC_O/STB_O fall without a clock edge, state returns to IDLE, and a later ACK_I pulse has no effect.
6. Back-to-back and conflict:
   - read then write held continuously -> DONE separates the two transfers; exactly 2 CYC_O assertions.
   - cpu_read=cpu_write=1 -> WE_O=1.
